// File: rtl/sqrt_iter_uns.sv
// sqrt_iter_uns: multi-cycle restoring unsigned square root, Q = floor(sqrt(X)), R = X - Q*Q.
// Resolves BitsPerCycle root bits per clock between a valid/ready input and a valid/ready output.
module sqrt_iter_uns #(
  parameter int widthX       = 16,
  parameter int BitsPerCycle = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [widthX-1:0]       x_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [(widthX+1)/2-1:0] q_o,
  output logic [(widthX+1)/2:0]   r_o,
  output logic                    busy_o
);

  localparam int widthQ = (widthX + 1) / 2;
  localparam int NIter  = (BitsPerCycle > 0) ? (widthQ / BitsPerCycle) : 1;
  localparam int CntW   = (NIter > 1) ? $clog2(NIter) : 1;
  localparam logic [CntW-1:0]   LastCnt = CntW'(NIter - 1);
  localparam logic [widthQ-1:0] OneQ    = widthQ'(1);

  if (widthX < 2) begin : g_bad_width
    $error("sqrt_iter_uns: widthX must be at least 2");
  end
  if (BitsPerCycle < 1) begin : g_bad_bpc
    $error("sqrt_iter_uns: BitsPerCycle must be at least 1");
  end else if ((widthQ % BitsPerCycle) != 0) begin : g_bad_div
    $error("sqrt_iter_uns: BitsPerCycle must divide (widthX+1)/2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [2*widthQ-1:0]   x_q, x_d;
  logic [widthQ-1:0]     q_q, q_d;
  logic [widthQ+1:0]     r_q, r_d;
  logic [widthQ-1:0]     q_res_q, q_res_d;
  logic [widthQ:0]       r_res_q, r_res_d;

  logic [2*widthQ-1:0]   x_ext_s;
  logic [2*widthQ-1:0]   x_step_s;
  logic [widthQ-1:0]     q_step_s;
  logic [widthQ+1:0]     r_step_s;
  logic                  accept_s;

  assign in_ready_o  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign q_o         = q_res_q;
  assign r_o         = r_res_q;
  // Flush blocks acceptance even though in_ready_o stays independent of it.
  assign accept_s    = in_valid_i & in_ready_o & ~flush_i;

  // Zero-extend the operand to an even number of bits (odd widthX gets a leading 0).
  always_comb begin
    x_ext_s              = '0;
    x_ext_s[widthX-1:0]  = x_i;
  end

  // BitsPerCycle restoring steps, each consuming the next two operand MSBs.
  always_comb begin : step_logic
    logic [2*widthQ-1:0] x_v;
    logic [widthQ-1:0]   q_v;
    logic [widthQ+1:0]   r_v;
    logic [widthQ+1:0]   t_v;
    logic [widthQ+2:0]   d_v;
    x_v = x_q;
    q_v = q_q;
    r_v = r_q;
    t_v = '0;
    d_v = '0;
    for (int i = 0; i < BitsPerCycle; i++) begin
      t_v = {r_v[widthQ-1:0], x_v[2*widthQ-1 -: 2]};
      d_v = {1'b0, t_v} - {1'b0, q_v, 2'b01};
      if (d_v[widthQ+2] == 1'b0) begin
        r_v = d_v[widthQ+1:0];
        q_v = (q_v << 1) | OneQ;
      end else begin
        r_v = t_v;
        q_v = q_v << 1;
      end
      x_v = x_v << 2;
    end
    x_step_s = x_v;
    q_step_s = q_v;
    r_step_s = r_v;
  end

  // Next-state and datapath update for the IDLE/CALC/DONE controller.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    x_d     = x_q;
    q_d     = q_q;
    r_d     = r_q;
    q_res_d = q_res_q;
    r_res_d = r_res_q;
    if (flush_i) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            x_d     = x_ext_s;
            q_d     = '0;
            r_d     = '0;
            count_d = '0;
            state_d = S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          x_d = x_step_s;
          q_d = q_step_s;
          r_d = r_step_s;
          if (count_q == LastCnt) begin
            count_d = '0;
            q_res_d = q_step_s;
            r_res_d = r_step_s[widthQ:0];
            state_d = S_DONE;
          end else begin
            count_d = count_q + {{(CntW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            if (accept_s) begin
              x_d     = x_ext_s;
              q_d     = '0;
              r_d     = '0;
              count_d = '0;
              state_d = S_CALC;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      count_q <= '0;
      x_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      q_res_q <= '0;
      r_res_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      x_q     <= x_d;
      q_q     <= q_d;
      r_q     <= r_d;
      q_res_q <= q_res_d;
      r_res_q <= r_res_d;
    end
  end

endmodule

// File: tb/tb_sqrt_iter_uns.sv
// tb_sqrt_iter_uns: self-checking bench running several widthX/BitsPerCycle configurations in parallel,
// with directed vectors, back-to-back, reset/flush sequences and randomized stall traffic.
module tb_sqrt_iter_uns;

  localparam int NCFG = 5;
  localparam int CFG_WX  [NCFG] = '{16, 16, 9, 8, 17};
  localparam int CFG_BPC [NCFG] = '{1, 2, 1, 4, 1};
  localparam int NCYC = 6000;
  localparam int NVEC = 10;

  typedef struct {
    int     cfg;
    longint x;
    longint q;
    longint r;
    int     lat;
    int     stall;
  } vec_t;

  vec_t vecs [NVEC];
  logic clk;
  int   errors = 0;
  int   checks = 0;
  bit   done_v [NCFG];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    vecs[0] = '{0, 144, 12, 0, 8, 0};
    vecs[1] = '{0, 65535, 255, 510, 8, 2};
    vecs[2] = '{0, 0, 0, 0, 8, 0};
    vecs[3] = '{1, 50000, 223, 271, 4, 6};
    vecs[4] = '{2, 511, 22, 27, 5, 0};
    vecs[5] = '{2, 256, 16, 0, 5, 1};
    vecs[6] = '{3, 255, 15, 30, 1, 0};
    vecs[7] = '{3, 1, 1, 0, 1, 3};
    vecs[8] = '{4, 131071, 362, 27, 9, 0};
    vecs[9] = '{4, 2, 1, 1, 9, 2};
  end

  // Reference model: largest q with q*q <= x, by plain arithmetic.
  function automatic longint isqrt(input longint x);
    longint q;
    q = longint'($sqrt(real'(x)));
    while (q * q > x) q = q - 1;
    while ((q + 1) * (q + 1) <= x) q = q + 1;
    return q;
  endfunction

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s cfg%0d: got %0d, expected %0d", nm, g, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int WX = CFG_WX[g];
    localparam int WQ = (WX + 1) / 2;
    localparam int NI = WQ / CFG_BPC[g];

    logic          rst_n_s, in_valid_s, in_ready_s, flush_s;
    logic          out_valid_s, out_ready_s, busy_s;
    logic [WX-1:0] x_s;
    logic [WQ-1:0] q_s;
    logic [WQ:0]   r_s;

    sqrt_iter_uns #(.widthX(WX), .BitsPerCycle(CFG_BPC[g])) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n_s),
      .in_valid_i  (in_valid_s),
      .in_ready_o  (in_ready_s),
      .x_i         (x_s),
      .flush_i     (flush_s),
      .out_valid_o (out_valid_s),
      .out_ready_i (out_ready_s),
      .q_o         (q_s),
      .r_o         (r_s),
      .busy_o      (busy_s)
    );

    initial begin : run
      longint        q_x [$];
      longint        ex, eq;
      int            lat, cyc, last, nout, nin;
      bit            stalled, acc, seen, inv;
      logic [WQ-1:0] hq;
      logic [WQ:0]   hr;
      longint        b2b_q [4];
      longint        b2b_r [4];
      b2b_q = '{1, 1, 1, 2};
      b2b_r = '{0, 1, 2, 0};

      rst_n_s = 1'b0; in_valid_s = 1'b0; flush_s = 1'b0; out_ready_s = 1'b0; x_s = '0;
      tick;
      tick;
      chk("reset_in_ready", g, 64'(in_ready_s), 64'd1);
      chk("reset_out_valid", g, 64'(out_valid_s), 64'd0);
      chk("reset_busy", g, 64'(busy_s), 64'd0);
      chk("reset_q", g, 64'(q_s), 64'd0);
      chk("reset_r", g, 64'(r_s), 64'd0);
      rst_n_s = 1'b1;
      tick;

      // Directed vectors with a stalled consumer.
      for (int i = 0; i < NVEC; i++) begin
        if (vecs[i].cfg == g) begin
          x_s = WX'(vecs[i].x);
          in_valid_s = 1'b1;
          #1;
          chk("vec_in_ready", g, 64'(in_ready_s), 64'd1);
          tick;
          in_valid_s = 1'b0;
          x_s = ~x_s;
          lat = 0;
          while (!out_valid_s && lat < 4 * NI + 8) begin
            tick;
            lat = lat + 1;
          end
          chk("vec_latency", g, 64'(lat), 64'(vecs[i].lat));
          chk("vec_q", g, 64'(q_s), 64'(vecs[i].q));
          chk("vec_r", g, 64'(r_s), 64'(vecs[i].r));
          for (int s = 0; s < vecs[i].stall; s++) begin
            tick;
            chk("stall_state", g, {60'd0, out_valid_s, in_ready_s, q_s == WQ'(vecs[i].q), r_s == (WQ+1)'(vecs[i].r)},
                64'b1011);
          end
          out_ready_s = 1'b1;
          #1;
          chk("done_in_ready", g, 64'(in_ready_s), 64'd1);
          tick;
          out_ready_s = 1'b0;
          chk("after_hs_idle", g, {62'd0, out_valid_s, busy_s}, 64'd0);
          chk("after_hs_hold_q", g, 64'(q_s), 64'(vecs[i].q));
        end
      end

      // Back-to-back operands 1..4 with consumer always ready.
      cyc = 0; nin = 0; nout = 0; last = 0;
      in_valid_s = 1'b1; out_ready_s = 1'b1; x_s = WX'(1);
      while (nout < 4 && cyc < 20 * (NI + 1) + 10) begin
        #1;
        if (out_valid_s) begin
          chk("b2b_q", g, 64'(q_s), 64'(b2b_q[nout]));
          chk("b2b_r", g, 64'(r_s), 64'(b2b_r[nout]));
          if (nout > 0) chk("b2b_spacing", g, 64'(cyc - last), 64'(NI + 1));
          last = cyc;
          nout = nout + 1;
        end
        acc = in_valid_s & in_ready_s;
        tick;
        cyc = cyc + 1;
        if (acc) begin
          nin = nin + 1;
          if (nin < 4) x_s = WX'(nin + 1);
          else in_valid_s = 1'b0;
        end
      end
      chk("b2b_count", g, 64'(nout), 64'd4);
      in_valid_s = 1'b0; out_ready_s = 1'b0;
      tick;

      // Reset during the third cycle after accept discards the operation.
      x_s = WX'(3); in_valid_s = 1'b1;
      tick;
      in_valid_s = 1'b0;
      tick;
      tick;
      rst_n_s = 1'b0;
      tick;
      rst_n_s = 1'b1;
      chk("rst_mid_state", g, {61'd0, out_valid_s, in_ready_s, busy_s}, 64'b010);
      seen = 1'b0;
      for (int k = 0; k < NI + 3; k++) begin
        tick;
        if (out_valid_s) seen = 1'b1;
      end
      chk("rst_mid_no_result", g, 64'(seen), 64'd0);

      // Flush in DONE, flush mid-operation, flush in IDLE.
      x_s = WX'(144); in_valid_s = 1'b1;
      tick;
      in_valid_s = 1'b0;
      lat = 0;
      while (!out_valid_s && lat < 4 * NI + 8) begin
        tick;
        lat = lat + 1;
      end
      chk("flush_pre_valid", g, 64'(out_valid_s), 64'd1);
      flush_s = 1'b1; in_valid_s = 1'b1; x_s = WX'(5);
      tick;
      flush_s = 1'b0; in_valid_s = 1'b0;
      chk("flush_done_state", g, {62'd0, out_valid_s, busy_s}, 64'd0);
      chk("flush_hold_q", g, 64'(q_s), 64'(isqrt(144)));
      chk("flush_hold_r", g, 64'(r_s), 64'(144 - isqrt(144) * isqrt(144)));
      x_s = WX'(50); in_valid_s = 1'b1;
      tick;
      in_valid_s = 1'b0; flush_s = 1'b1;
      tick;
      flush_s = 1'b0;
      chk("flush_calc_state", g, {62'd0, out_valid_s, busy_s}, 64'd0);
      flush_s = 1'b1;
      tick;
      flush_s = 1'b0;
      chk("flush_idle_state", g, {61'd0, in_ready_s, out_valid_s, busy_s}, 64'b100);

      // Randomized traffic with input gaps and output stalls, then a drain phase.
      stalled = 1'b0; hq = '0; hr = '0;
      for (int c = 0; c < NCYC + 4 * NI + 8; c++) begin
        if (c < NCYC) begin
          in_valid_s  = ($urandom_range(0, 3) != 0);
          out_ready_s = ($urandom_range(0, 2) != 0);
        end else begin
          in_valid_s  = 1'b0;
          out_ready_s = 1'b1;
        end
        x_s = WX'($urandom());
        #1;
        if (stalled) chk("stall_hold", g, {61'd0, out_valid_s, q_s == hq, r_s == hr}, 64'd7);
        if (out_valid_s && !stalled) begin
          chk("result_expected", g, 64'(q_x.size() != 0), 64'd1);
          if (q_x.size() != 0) begin
            ex = q_x[0];
            eq = isqrt(ex);
            chk("rand_q", g, 64'(q_s), 64'(eq));
            chk("rand_r", g, 64'(r_s), 64'(ex - eq * eq));
            inv = ((64'(q_s) * 64'(q_s) + 64'(r_s)) == 64'(ex)) && (64'(r_s) <= 2 * 64'(q_s));
            chk("rand_invariant", g, 64'(inv), 64'd1);
          end
        end
        if (out_valid_s && out_ready_s && q_x.size() != 0) void'(q_x.pop_front());
        stalled = out_valid_s && !out_ready_s;
        hq = q_s;
        hr = r_s;
        if (in_valid_s && in_ready_s) q_x.push_back(longint'(x_s));
        tick;
      end
      chk("drain_empty", g, 64'(q_x.size()), 64'd0);
      out_ready_s = 1'b0;
      done_v[g] = 1'b1;
    end
  end

  initial begin : summary
    int waited;
    bit all_done;
    waited = 0;
    all_done = 1'b0;
    while (!all_done && waited < 90000) begin
      @(posedge clk);
      waited = waited + 1;
      all_done = 1'b1;
      for (int k = 0; k < NCFG; k++) if (!done_v[k]) all_done = 1'b0;
    end
    if (!all_done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL timeout: got running after %0d cycles, expected all configs finished", waited);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
